// File: rtl/tpu_tile_scheduler_if.sv
// Host-command and TPU-core handshake bundle for tpu_tile_scheduler.
// master = host/core side, slave = the scheduler itself.
interface tpu_tile_scheduler_if #(
   parameter int IDX_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_K;
   logic [7:0]       cmd_M;
   logic [7:0]       cmd_N;
   logic             core_start;
   logic [7:0]       core_K;
   logic [7:0]       core_M;
   logic [7:0]       core_N;
   logic             core_busy;
   logic [IDX_W-1:0] a_base;
   logic [IDX_W-1:0] b_base;
   logic [IDX_W-1:0] c_base;
   logic [IDX_W-1:0] tile_cnt;
   logic             done;

   modport master (
      output cmd_valid, cmd_K, cmd_M, cmd_N, core_busy,
      input  cmd_ready, core_start, core_K, core_M, core_N,
             a_base, b_base, c_base, tile_cnt, done
   );

   modport slave (
      input  cmd_valid, cmd_K, cmd_M, cmd_N, core_busy,
      output cmd_ready, core_start, core_K, core_M, core_N,
             a_base, b_base, c_base, tile_cnt, done
   );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Splits a K x M x N job into ROWS x COLS tiles and sequences the systolic core.
// Optional TILE_SCHED_PERF_EN adds a saturating job_cycles counter output.
module tpu_tile_scheduler #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int IDX_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   tpu_tile_scheduler_if.slave bus
`ifdef TILE_SCHED_PERF_EN
   ,
   output logic [31:0] job_cycles
`endif
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAIT_ACK = 3'd2;
   localparam logic [2:0] S_RUN      = 3'd3;
   localparam logic [2:0] S_NEXT     = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [7:0]       ROWS_8 = 8'(ROWS);
   localparam logic [7:0]       COLS_8 = 8'(COLS);
   localparam logic [IDX_W-1:0] ROWS_W = IDX_W'(ROWS);

   logic [2:0]       state;
   logic [7:0]       m_q, n_q;
   logic [7:0]       tm_last, tn_last;
   logic [7:0]       tm, tn;
   logic [7:0]       core_k, core_m, core_n;
   logic [IDX_W-1:0] a_base, b_base, c_base, tile_cnt;
   logic [IDX_W-1:0] k_w;
   logic             accept;
   logic             last_tile;

   // Index of the last tile along one axis: ceil(dim/tile) - 1, kept in 9 bits.
   function automatic logic [7:0] last_idx(input logic [7:0] dim, input logic [7:0] tile);
      logic [8:0] sum;
      sum = {1'b0, dim} + {1'b0, tile} - 9'd1;
      return 8'(sum / {1'b0, tile}) - 8'd1;
   endfunction

   function automatic logic [7:0] tile_dim(input logic [7:0] dim, input logic [7:0] idx,
                                           input logic [7:0] tile);
      logic [15:0] rem;
      rem = 16'(dim) - 16'(idx) * 16'(tile);
      return (rem < 16'(tile)) ? rem[7:0] : tile;
   endfunction

   assign accept    = (state == S_IDLE) && bus.cmd_valid;
   assign last_tile = (tm == tm_last) && (tn == tn_last);
   assign k_w       = IDX_W'(core_k);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         m_q      <= '0;
         n_q      <= '0;
         tm_last  <= '0;
         tn_last  <= '0;
         tm       <= '0;
         tn       <= '0;
         core_k   <= '0;
         core_m   <= '0;
         core_n   <= '0;
         a_base   <= '0;
         b_base   <= '0;
         c_base   <= '0;
         tile_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  m_q      <= bus.cmd_M;
                  n_q      <= bus.cmd_N;
                  tm_last  <= last_idx(bus.cmd_M, ROWS_8);
                  tn_last  <= last_idx(bus.cmd_N, COLS_8);
                  tm       <= '0;
                  tn       <= '0;
                  tile_cnt <= '0;
                  if (bus.cmd_K == 8'd0 || bus.cmd_M == 8'd0 || bus.cmd_N == 8'd0) begin
                     state <= S_DONE;
                  end else begin
                     state  <= S_ISSUE;
                     core_k <= bus.cmd_K;
                     core_m <= tile_dim(bus.cmd_M, 8'd0, ROWS_8);
                     core_n <= tile_dim(bus.cmd_N, 8'd0, COLS_8);
                     a_base <= '0;
                     b_base <= '0;
                     c_base <= '0;
                  end
               end
            end
            S_ISSUE:    state <= S_WAIT_ACK;
            S_WAIT_ACK: if (bus.core_busy)  state <= S_RUN;
            S_RUN:      if (!bus.core_busy) state <= S_NEXT;
            S_NEXT: begin
               tile_cnt <= tile_cnt + 1'b1;
               if (last_tile) begin
                  state <= S_DONE;
               end else begin
                  state  <= S_ISSUE;
                  c_base <= c_base + ROWS_W;
                  // Bases advance incrementally; wrap-around matches truncated products.
                  if (tm == tm_last) begin
                     tm     <= '0;
                     tn     <= tn + 8'd1;
                     a_base <= '0;
                     b_base <= b_base + k_w;
                     core_m <= tile_dim(m_q, 8'd0, ROWS_8);
                     core_n <= tile_dim(n_q, tn + 8'd1, COLS_8);
                  end else begin
                     tm     <= tm + 8'd1;
                     a_base <= a_base + k_w;
                     core_m <= tile_dim(m_q, tm + 8'd1, ROWS_8);
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready  = (state == S_IDLE);
   assign bus.core_start = (state == S_ISSUE);
   assign bus.done       = (state == S_DONE);
   assign bus.core_K     = core_k;
   assign bus.core_M     = core_m;
   assign bus.core_N     = core_n;
   assign bus.a_base     = a_base;
   assign bus.b_base     = b_base;
   assign bus.c_base     = c_base;
   assign bus.tile_cnt   = tile_cnt;

`ifdef TILE_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_cycles <= '0;
      end else if (accept) begin
         job_cycles <= '0;
      end else if (state != S_IDLE && job_cycles != '1) begin
         job_cycles <= job_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed, table-driven bench for tpu_tile_scheduler; acts as both host and TPU core.
module tb_tpu_tile_scheduler;

   logic clk;
   logic rst_n;

   tpu_tile_scheduler_if #(.IDX_W(16)) bus ();

`ifdef TILE_SCHED_PERF_EN
   logic [31:0] job_cycles;
`endif

   tpu_tile_scheduler #(.ROWS(4), .COLS(4), .IDX_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef TILE_SCHED_PERF_EN
      ,
      .job_cycles (job_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] k, m, n;
      int         tiles;
      int         first;
   } job_t;

   typedef struct {
      logic [7:0]  cm, cn;
      logic [15:0] a, b, c;
   } tile_t;

   job_t  jobs[7];
   tile_t exp_tiles[16];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_cmd(input job_t j, input bit hold);
      bus.cmd_K     = j.k;
      bus.cmd_M     = j.m;
      bus.cmd_N     = j.n;
      bus.cmd_valid = 1'b1;
      check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      step();
      if (!hold) bus.cmd_valid = 1'b0;
   endtask

   // Arrive in ISSUE, act as the core for one tile, return two cycles after busy falls.
   task automatic serve_tile(input string tag, input tile_t t, input logic [7:0] k, input bit last);
      check({tag, "_start"}, 32'(bus.core_start), 32'd1);
      check({tag, "_K"},     32'(bus.core_K), 32'(k));
      check({tag, "_M"},     32'(bus.core_M), 32'(t.cm));
      check({tag, "_N"},     32'(bus.core_N), 32'(t.cn));
      check({tag, "_a"},     32'(bus.a_base), 32'(t.a));
      check({tag, "_b"},     32'(bus.b_base), 32'(t.b));
      check({tag, "_c"},     32'(bus.c_base), 32'(t.c));
      step();
      check({tag, "_pulse"}, 32'(bus.core_start), 32'd0);
      bus.core_busy = 1'b1;
      step();
      check({tag, "_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
      step();
      step();
      bus.core_busy = 1'b0;
      step();
      check({tag, "_no_done_next"}, 32'(bus.done), 32'd0);
      step();
      if (last) check({tag, "_done"}, 32'(bus.done), 32'd1);
   endtask

   task automatic run_job(input int ji, input bit hold);
      job_t  j;
      string tag;
      j = jobs[ji];
      start_cmd(j, hold);
      if (j.tiles == 0) begin
         check($sformatf("j%0d_zero_done", ji),  32'(bus.done), 32'd1);
         check($sformatf("j%0d_zero_start", ji), 32'(bus.core_start), 32'd0);
      end else begin
         for (int t = 0; t < j.tiles; t++) begin
            tag = $sformatf("j%0d_t%0d", ji, t);
            serve_tile(tag, exp_tiles[j.first + t], j.k, (t == j.tiles - 1));
         end
      end
      step();
      check($sformatf("j%0d_done_width", ji), 32'(bus.done), 32'd0);
      check($sformatf("j%0d_ready_after", ji), 32'(bus.cmd_ready), 32'd1);
      check($sformatf("j%0d_tile_cnt", ji), 32'(bus.tile_cnt), 32'(j.tiles));
   endtask

   initial begin
      // Jobs: {K, M, N, tiles, first tile record}
      jobs[0] = '{8'd4, 8'd4, 8'd4, 1, 0};
      jobs[1] = '{8'd8, 8'd8, 8'd8, 4, 1};
      jobs[2] = '{8'd3, 8'd6, 8'd5, 4, 5};
      jobs[3] = '{8'd4, 8'd0, 8'd4, 0, 0};
      jobs[4] = '{8'd2, 8'd9, 8'd1, 3, 9};
      jobs[5] = '{8'd0, 8'd4, 8'd4, 0, 0};
      jobs[6] = '{8'd5, 8'd4, 8'd9, 3, 12};
      // Tiles: {core_M, core_N, a_base, b_base, c_base}
      exp_tiles[0]  = '{8'd4, 8'd4, 16'd0, 16'd0, 16'd0};
      exp_tiles[1]  = '{8'd4, 8'd4, 16'd0, 16'd0, 16'd0};
      exp_tiles[2]  = '{8'd4, 8'd4, 16'd8, 16'd0, 16'd4};
      exp_tiles[3]  = '{8'd4, 8'd4, 16'd0, 16'd8, 16'd8};
      exp_tiles[4]  = '{8'd4, 8'd4, 16'd8, 16'd8, 16'd12};
      exp_tiles[5]  = '{8'd4, 8'd4, 16'd0, 16'd0, 16'd0};
      exp_tiles[6]  = '{8'd2, 8'd4, 16'd3, 16'd0, 16'd4};
      exp_tiles[7]  = '{8'd4, 8'd1, 16'd0, 16'd3, 16'd8};
      exp_tiles[8]  = '{8'd2, 8'd1, 16'd3, 16'd3, 16'd12};
      exp_tiles[9]  = '{8'd4, 8'd1, 16'd0, 16'd0, 16'd0};
      exp_tiles[10] = '{8'd4, 8'd1, 16'd2, 16'd0, 16'd4};
      exp_tiles[11] = '{8'd1, 8'd1, 16'd4, 16'd0, 16'd8};
      exp_tiles[12] = '{8'd4, 8'd4, 16'd0, 16'd0, 16'd0};
      exp_tiles[13] = '{8'd4, 8'd4, 16'd0, 16'd5, 16'd4};
      exp_tiles[14] = '{8'd4, 8'd1, 16'd0, 16'd10, 16'd8};
      exp_tiles[15] = '{8'd0, 8'd0, 16'd0, 16'd0, 16'd0};

      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_K     = '0;
      bus.cmd_M     = '0;
      bus.cmd_N     = '0;
      bus.core_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready",  32'(bus.cmd_ready), 32'd1);
      check("rst_core_start", 32'(bus.core_start), 32'd0);
      check("rst_done",       32'(bus.done), 32'd0);
      check("rst_tile_cnt",   32'(bus.tile_cnt), 32'd0);
      check("rst_core_M",     32'(bus.core_M), 32'd0);
      rst_n = 1'b1;
      step();

      run_job(0, 1'b0);
`ifdef TILE_SCHED_PERF_EN
      check("job_cycles_j0", job_cycles, 32'd7);
`endif
      for (int i = 1; i < 7; i++) run_job(i, 1'b0);

      // cmd_valid held through a job: no early re-accept, next job only from IDLE.
      run_job(0, 1'b1);
      run_job(2, 1'b0);

      // Reset while the core is running the second tile of the 8x8x8 job.
      start_cmd(jobs[1], 1'b0);
      serve_tile("rst_j1_t0", exp_tiles[1], 8'd8, 1'b0);
      check("rst_pre_a_base", 32'(bus.a_base), 32'd8);
      step();
      bus.core_busy = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("midrst_a_base",    32'(bus.a_base), 32'd0);
      check("midrst_tile_cnt",  32'(bus.tile_cnt), 32'd1 - 32'd1);
      check("midrst_core_M",    32'(bus.core_M), 32'd0);
      step();
      rst_n = 1'b1;
      bus.core_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("postrst_no_done_%0d", i), 32'(bus.done), 32'd0);
      end
      run_job(1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
